// File: rtl/inst_fetch.sv
// Instruction fetch and field-split unit: owns the PC, fetches words over a req/ack
// handshake and presents the decoded MIPS fields to the datapath under valid/ready.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ack,
   input  logic [31:0] inst_data,
   output logic        fields_valid,
   input  logic        dp_ready,
   output logic [5:0]  opcode,
   output logic [4:0]  rs_num,
   output logic [4:0]  rt_num,
   output logic [4:0]  rd_num,
   output logic [4:0]  sh_mount,
   output logic [5:0]  func,
   output logic [15:0] imm,
   output logic [31:0] pc_value,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halted,
   output logic        addr_err,
   output logic [31:0] inst_count
);

   typedef enum logic [1:0] {StReq, StIssue, StHalt} state_e;

   state_e      state_q, state_d;
   logic        started_q;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_value_q, pc_value_d;
   logic [31:0] count_q, count_d;
   logic        addr_err_q, addr_err_d;

   // started_q keeps inst_req low for the cycle in which reset is released, so a
   // stray ack during that cycle is ignored.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= StReq;
         started_q  <= 1'b0;
         pc_q       <= RESET_PC;
         inst_q     <= '0;
         pc_value_q <= '0;
         count_q    <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         started_q  <= 1'b1;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         pc_value_q <= pc_value_d;
         count_q    <= count_d;
         addr_err_q <= addr_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      pc_value_d = pc_value_q;
      count_d    = count_q;
      addr_err_d = addr_err_q;
      if (halted) begin
         state_d = StHalt;
      end else begin
         unique case (state_q)
            StReq: begin
               if (inst_req && inst_ack) begin
                  inst_d     = inst_data;
                  pc_value_d = pc_q;
                  state_d    = StIssue;
               end
            end
            StIssue: begin
               if (dp_ready) begin
                  count_d = count_q + 32'd1;
                  state_d = StReq;
                  if (redirect_valid) begin
                     if (redirect_pc[1:0] == 2'b00) begin
                        pc_d = redirect_pc;
                     end else begin
                        addr_err_d = 1'b1;
                        state_d    = StHalt;
                     end
                  end else begin
                     pc_d = pc_value_q + 32'(PC_STEP);
                  end
               end
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
         endcase
      end
   end

   always_comb begin
      inst_req     = (state_q == StReq) && started_q;
      fields_valid = (state_q == StIssue);
      inst_addr    = started_q ? pc_q : 32'h0;
   end

   assign opcode     = inst_q[31:26];
   assign rs_num     = inst_q[25:21];
   assign rt_num     = inst_q[20:16];
   assign rd_num     = inst_q[15:11];
   assign sh_mount   = inst_q[10:6];
   assign func       = inst_q[5:0];
   assign imm        = inst_q[15:0];
   assign pc_value   = pc_value_q;
   assign addr_err   = addr_err_q;
   assign inst_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; inputs change and outputs are
// sampled on the falling clock edge.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic [31:0] inst_data;
   logic        fields_valid;
   logic        dp_ready;
   logic [5:0]  opcode;
   logic [4:0]  rs_num, rt_num, rd_num, sh_mount;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [31:0] pc_value;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        addr_err;
   logic [31:0] inst_count;

   int checks = 0;
   int errors = 0;

   inst_fetch dut (
      .clk           (clk),
      .rst_b         (rst_b),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_ack      (inst_ack),
      .inst_data     (inst_data),
      .fields_valid  (fields_valid),
      .dp_ready      (dp_ready),
      .opcode        (opcode),
      .rs_num        (rs_num),
      .rt_num        (rt_num),
      .rd_num        (rd_num),
      .sh_mount      (sh_mount),
      .func          (func),
      .imm           (imm),
      .pc_value      (pc_value),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halted        (halted),
      .addr_err      (addr_err),
      .inst_count    (inst_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string tag, input logic [31:0] addr);
      chk({tag, ".req"}, 32'(inst_req), 32'd1);
      chk({tag, ".fv"}, 32'(fields_valid), 32'd0);
      chk({tag, ".addr"}, inst_addr, addr);
   endtask

   task automatic chk_issue(input string tag, input logic [31:0] pc);
      chk({tag, ".req"}, 32'(inst_req), 32'd0);
      chk({tag, ".fv"}, 32'(fields_valid), 32'd1);
      chk({tag, ".pc"}, pc_value, pc);
   endtask

   initial begin
      rst_b = 1'b0; inst_ack = 1'b0; inst_data = '0; dp_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; halted = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst.req", 32'(inst_req), 32'd0);
      chk("rst.addr", inst_addr, 32'd0);
      chk("rst.fv", 32'(fields_valid), 32'd0);
      chk("rst.imm", 32'(imm), 32'd0);
      chk("rst.pc", pc_value, 32'd0);
      chk("rst.err", 32'(addr_err), 32'd0);
      chk("rst.cnt", inst_count, 32'd0);
      rst_b = 1'b1;
      @(negedge clk);

      // Back-to-back fetches, immediate ack and ready
      inst_ack = 1'b1; dp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inst_data = 32'(i * 4);
         chk_req("seq", 32'(i * 4));
         @(negedge clk);
         chk_issue("seq", 32'(i * 4));
         chk("seq.imm", 32'(imm), 32'(i * 4));
         @(negedge clk);
      end
      chk_req("seq.end", 32'd16);
      chk("seq.cnt", inst_count, 32'd4);

      // Field split of add $8,$17,$18
      inst_data = 32'h0232_4020; dp_ready = 1'b0;
      @(negedge clk);
      inst_ack = 1'b0;
      chk_issue("add", 32'd16);
      chk("add.op", 32'(opcode), 32'd0);
      chk("add.rs", 32'(rs_num), 32'd17);
      chk("add.rt", 32'(rt_num), 32'd18);
      chk("add.rd", 32'(rd_num), 32'd8);
      chk("add.sh", 32'(sh_mount), 32'd0);
      chk("add.func", 32'(func), 32'h20);
      chk("add.imm", 32'(imm), 32'h4020);
      dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0;
      chk_req("add.next", 32'd20);
      chk("add.cnt", inst_count, 32'd5);

      // Ack delayed 5 cycles, then ready withheld 3 cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_req("wait", 32'd20);
      end
      inst_data = 32'h8C28_0010; inst_ack = 1'b1;
      @(negedge clk);
      inst_ack = 1'b0;
      chk_issue("lw", 32'd20);
      chk("lw.op", 32'(opcode), 32'h23);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_issue("stall", 32'd20);
         chk("stall.imm", 32'(imm), 32'h0010);
         chk("stall.rs", 32'(rs_num), 32'd1);
         chk("stall.cnt", inst_count, 32'd5);
      end
      dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0;
      chk_req("lw.next", 32'd24);
      chk("lw.cnt", inst_count, 32'd6);

      // Aligned redirect to 0x100
      inst_ack = 1'b1;
      @(negedge clk);
      inst_ack = 1'b0; dp_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0; dp_ready = 1'b0;
      chk_req("redir", 32'h100);
      chk("redir.cnt", inst_count, 32'd7);

      // Redirect to top of memory, then sequential wrap to 0
      inst_ack = 1'b1;
      @(negedge clk);
      inst_ack = 1'b0; dp_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0; dp_ready = 1'b0;
      chk_req("top", 32'hFFFF_FFFC);
      inst_ack = 1'b1;
      @(negedge clk);
      chk_issue("top", 32'hFFFF_FFFC);
      inst_ack = 1'b0; dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0;
      chk_req("wrap", 32'h0);
      chk("wrap.cnt", inst_count, 32'd9);

      // Misaligned redirect halts with addr_err; stray acks ignored
      inst_ack = 1'b1;
      @(negedge clk);
      inst_ack = 1'b0; dp_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0; dp_ready = 1'b0;
      chk("mis.err", 32'(addr_err), 32'd1);
      chk("mis.cnt", inst_count, 32'd10);
      inst_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mis.req", 32'(inst_req), 32'd0);
         chk("mis.fv", 32'(fields_valid), 32'd0);
      end
      inst_ack = 1'b0;
      rst_b = 1'b0;
      #1;
      chk("mis.rst.err", 32'(addr_err), 32'd0);
      chk("mis.rst.cnt", inst_count, 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      chk_req("restart", 32'h0);

      // One accept so the count is non-zero, then halt on the ack edge
      inst_ack = 1'b1; inst_data = 32'h0000_0020;
      @(negedge clk);
      inst_ack = 1'b0; dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0;
      chk_req("pre", 32'h4);
      chk("pre.cnt", inst_count, 32'd1);
      inst_ack = 1'b1; inst_data = 32'hFFFF_FFFF; halted = 1'b1;
      @(negedge clk);
      inst_ack = 1'b0; halted = 1'b0;
      chk("halt.fv", 32'(fields_valid), 32'd0);
      chk("halt.req", 32'(inst_req), 32'd0);
      chk("halt.imm", 32'(imm), 32'h0020);
      chk("halt.cnt", inst_count, 32'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("halt.hold", 32'(inst_req), 32'd0);
      end

      // Reset pulse between clock edges restarts fetch at RESET_PC
      #2 rst_b = 1'b0;
      #1;
      chk("pulse.cnt", inst_count, 32'd0);
      chk("pulse.req", 32'(inst_req), 32'd0);
      #1 rst_b = 1'b1;
      @(negedge clk);
      chk_req("pulse", 32'h0);
      chk("pulse.cnt2", inst_count, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
